// File: rtl/ws2812_chain_out.sv
// Multi-channel WS2812 serializer: shifts CH pixel words MSB-first in lockstep with
// programmable high/period timing, then optionally holds all lines low for the latch period.
module ws2812_chain_out #(
  parameter int unsigned CH        = 4,
  parameter int unsigned WORD_BITS = 24,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CNT_T0H   = 70,
  parameter int unsigned CNT_T1H   = 140,
  parameter int unsigned CNT_BIT   = 250,
  parameter int unsigned CNT_RST   = 60000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    data_vld_in,
  input  logic [CH*WORD_BITS-1:0] data_in,
  output logic                    data_rdy_out,
  input  logic                    latch_in,
  output logic                    busy_out,
  output logic                    word_done_out,
  output logic [CH-1:0]           ws2812_data_out
);

  localparam int unsigned IDX_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CNT_BIT - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(CNT_RST - 1);
  localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(CNT_T0H);
  localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(CNT_T1H);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WORD_BITS - 1);

  logic [1:0]                      state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                bit_idx_q, bit_idx_d;
  logic                            latch_pend_q, latch_pend_d;
  logic [CH-1:0][WORD_BITS-1:0]    sh_q, sh_d;
  logic                            done_q, done_d;
  logic [CH-1:0]                   line_q, line_d;

  logic             bit_end_c;
  logic             word_end_c;
  logic             go_latch_c;
  logic             accept_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // cnt_q is the position within the bit currently shown on the lines
  assign cnt_inc_c  = cnt_q + CNT_W'(1);
  assign bit_end_c  = (cnt_q == BIT_LAST);
  assign word_end_c = bit_end_c && (bit_idx_q == '0);
  assign go_latch_c = latch_pend_q | latch_in;

  assign data_rdy_out = (state_q == S_IDLE) ||
                        ((state_q == S_SEND) && word_end_c && !go_latch_c);
  assign accept_c     = data_vld_in & data_rdy_out;

  assign busy_out        = (state_q != S_IDLE);
  assign word_done_out   = done_q;
  assign ws2812_data_out = line_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    latch_pend_d = latch_pend_q;
    sh_d         = sh_q;
    done_d       = 1'b0;
    line_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          sh_d         = data_in;
          bit_idx_d    = IDX_MSB;
          cnt_d        = '0;
          latch_pend_d = latch_in;
          line_d       = '1;
          state_d      = S_SEND;
        end else if (latch_in) begin
          cnt_d   = '0;
          state_d = S_LATCH;
        end
      end

      S_SEND: begin
        latch_pend_d = latch_pend_q | latch_in;
        if (!bit_end_c) begin
          cnt_d = cnt_inc_c;
          for (int unsigned c = 0; c < CH; c++) begin
            line_d[c] = (cnt_inc_c < (sh_q[c][WORD_BITS-1] ? T1H_C : T0H_C));
          end
        end else if (bit_idx_q != '0) begin
          // every bit starts high regardless of its value
          cnt_d     = '0;
          bit_idx_d = bit_idx_q - IDX_W'(1);
          for (int unsigned c = 0; c < CH; c++) begin
            sh_d[c] = sh_q[c] << 1;
          end
          line_d = '1;
        end else begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (go_latch_c) begin
            latch_pend_d = 1'b0;
            state_d      = S_LATCH;
          end else if (accept_c) begin
            sh_d      = data_in;
            bit_idx_d = IDX_MSB;
            line_d    = '1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_LATCH: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      latch_pend_q <= 1'b0;
      sh_q         <= '0;
      done_q       <= 1'b0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      latch_pend_q <= latch_pend_d;
      sh_q         <= sh_d;
      done_q       <= done_d;
      line_q       <= line_d;
    end
  end

endmodule

// File: tb/tb_ws2812_chain_out.sv
// Bench for ws2812_chain_out: a full-timing instance with directed traffic and a
// small-timing instance with random traffic, both checked every cycle against a timestamp model.
module tb_ws2812_chain_out;

  typedef struct { int w; int bt; int t0; int t1; int rl; } prm_t;
  typedef struct { int mode; int a; int lend; bit lp; bit done; logic [1:0][31:0] word; } mdl_t;
  typedef struct { bit rdy; bit busy; bit done; logic [1:0] line; } exp_t;

  localparam prm_t PB = '{w: 24, bt: 250, t0: 70, t1: 140, rl: 60000};
  localparam prm_t PS = '{w: 8,  bt: 3,   t0: 1,  t1: 2,   rl: 4};

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        rst_b = 1'b1, vld_b = 1'b0, latch_b = 1'b0;
  logic [47:0] data_b = '0;
  logic        rdy_b, busy_b, done_b;
  logic [1:0]  line_b;

  logic        rst_s = 1'b1, vld_s = 1'b0, latch_s = 1'b0;
  logic [15:0] data_s = '0;
  logic        rdy_s, busy_s, done_s;
  logic [1:0]  line_s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ws2812_chain_out #(.CH(2), .WORD_BITS(24), .CNT_W(16), .CNT_T0H(70), .CNT_T1H(140),
                     .CNT_BIT(250), .CNT_RST(60000)) u_big (
    .clk_in(clk), .rst_in(rst_b), .data_vld_in(vld_b), .data_in(data_b),
    .data_rdy_out(rdy_b), .latch_in(latch_b), .busy_out(busy_b),
    .word_done_out(done_b), .ws2812_data_out(line_b));

  ws2812_chain_out #(.CH(2), .WORD_BITS(8), .CNT_W(4), .CNT_T0H(1), .CNT_T1H(2),
                     .CNT_BIT(3), .CNT_RST(4)) u_small (
    .clk_in(clk), .rst_in(rst_s), .data_vld_in(vld_s), .data_in(data_s),
    .data_rdy_out(rdy_s), .latch_in(latch_s), .busy_out(busy_s),
    .word_done_out(done_s), .ws2812_data_out(line_s));

  task automatic chk(input string nm, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Expected outputs from elapsed time since the accepting cycle
  task automatic m_eval(input mdl_t m, input prm_t p, input int n, input bit lat, output exp_t e);
    int t, b, pos;
    e.rdy = 1'b0; e.busy = 1'b0; e.done = m.done; e.line = '0;
    case (m.mode)
      0: e.rdy = 1'b1;
      1: begin
        e.busy = 1'b1;
        t   = n - m.a - 1;
        b   = t / p.bt;
        pos = t % p.bt;
        for (int c = 0; c < 2; c++)
          e.line[c] = (pos < (m.word[c][p.w-1-b] ? p.t1 : p.t0));
        e.rdy = (t == p.w * p.bt - 1) && !m.lp && !lat;
      end
      default: e.busy = 1'b1;
    endcase
  endtask

  task automatic m_step(input mdl_t mi, input prm_t p, input int n, input bit vld,
                        input logic [1:0][31:0] dw, input bit lat, output mdl_t mo);
    int t;
    mo = mi;
    mo.done = 1'b0;
    case (mi.mode)
      0: begin
        if (vld) begin mo.mode = 1; mo.a = n; mo.word = dw; mo.lp = lat; end
        else if (lat) begin mo.mode = 2; mo.lend = n + p.rl; end
      end
      1: begin
        t = n - mi.a - 1;
        if (lat) mo.lp = 1'b1;
        if (t == p.w * p.bt - 1) begin
          mo.done = 1'b1;
          if (mi.lp || lat) begin mo.mode = 2; mo.lend = n + p.rl; mo.lp = 1'b0; end
          else if (vld) begin mo.a = n; mo.word = dw; end
          else mo.mode = 0;
        end
      end
      default: if (n == mi.lend) mo.mode = 0;
    endcase
  endtask

  task automatic cmp(input string nm, input exp_t e, input bit r, input bit bz, input bit d,
                     input logic [1:0] l);
    total++;
    if ({r, bz, d, l} !== {e.rdy, e.busy, e.done, e.line}) begin
      bad++;
      $display("FAIL %s cyc=%0d rdy/busy/done/line got %b%b%b_%b expected %b%b%b_%b",
               nm, cyc, r, bz, d, l, e.rdy, e.busy, e.done, e.line);
    end
  endtask

  mdl_t mb = '{mode: 0, a: 0, lend: 0, lp: 1'b0, done: 1'b0, word: '0};
  mdl_t ms = '{mode: 0, a: 0, lend: 0, lp: 1'b0, done: 1'b0, word: '0};
  localparam exp_t E_IDLE = '{rdy: 1'b1, busy: 1'b0, done: 1'b0, line: 2'b00};

  // Single per-cycle compare against the model for both instances
  always @(negedge clk) begin
    exp_t e;
    mdl_t nx;
    if (rst_b) begin
      cmp("big_rst", E_IDLE, rdy_b, busy_b, done_b, line_b);
      mb.mode = 0; mb.lp = 1'b0; mb.done = 1'b0;
    end else begin
      m_eval(mb, PB, cyc, latch_b, e);
      cmp("big", e, rdy_b, busy_b, done_b, line_b);
      m_step(mb, PB, cyc, vld_b, {8'h0, data_b[47:24], 8'h0, data_b[23:0]}, latch_b, nx);
      mb = nx;
    end
    if (rst_s) begin
      cmp("small_rst", E_IDLE, rdy_s, busy_s, done_s, line_s);
      ms.mode = 0; ms.lp = 1'b0; ms.done = 1'b0;
    end else begin
      m_eval(ms, PS, cyc, latch_s, e);
      cmp("small", e, rdy_s, busy_s, done_s, line_s);
      m_step(ms, PS, cyc, vld_s, {24'h0, data_s[15:8], 24'h0, data_s[7:0]}, latch_s, nx);
      ms = nx;
    end
  end

  // Pulse log of channel 0 and word_done times on the full-timing instance
  int rise_t[64];
  int wid[64];
  int nr = 0;
  int done_t[$];
  logic prev_b0 = 1'b0;
  always @(negedge clk) begin
    if (!rst_b && line_b[0] && nr < 64) begin
      if (!prev_b0) begin rise_t[nr] = cyc; wid[nr] = 0; nr++; end
      wid[nr-1]++;
    end
    if (!rst_b && done_b) done_t.push_back(cyc);
    prev_b0 = rst_b ? 1'b0 : line_b[0];
  end

  task automatic run_big();
    int a0, a1, idle_c;
    bit ok;
    a1 = 0; idle_c = 0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    @(posedge clk); #1;
    vld_b = 1'b1; data_b = {24'h5AF07E, 24'hA50F81};
    a0 = cyc;
    @(posedge clk); #1 data_b = {24'hFFFFFE, 24'h000001};
    ok = 1'b0;
    for (int i = 0; i < 7000 && !ok; i++) begin
      @(negedge clk);
      if (rdy_b) begin a1 = cyc; ok = 1'b1; end
    end
    chk("b2b_ready_seen", ok, 1);
    @(posedge clk); #1 vld_b = 1'b0; data_b = {$urandom, $urandom};
    repeat (3000) @(posedge clk);
    #1 latch_b = 1'b1;
    @(posedge clk); #1 latch_b = 1'b0; data_b = {$urandom, $urandom};
    ok = 1'b0;
    for (int i = 0; i < 70000 && !ok; i++) begin
      @(negedge clk);
      if (!busy_b) begin idle_c = cyc; ok = 1'b1; end
    end
    chk("latch_end_seen", ok, 1);
    chk("b2b_accept_gap", a1 - a0, 6000);
    chk("rise_count", nr, 48);
    chk("done_count", done_t.size(), 2);
    if (nr >= 48 && done_t.size() >= 2) begin
      chk("first_rise", rise_t[0] - a0, 1);
      chk("done_after_accept", done_t[0] - a0, 6001);
      chk("done_spacing", done_t[1] - done_t[0], 6000);
      chk("word_boundary_rise", rise_t[24] - rise_t[23], 250);
      chk("w0_msb_t1h", wid[0], 140);
      chk("w0_bit1_t0h", wid[1], 70);
      chk("w0_lsb_t1h", wid[23], 140);
      chk("w1_msb_t0h", wid[24], 70);
      chk("w1_lsb_t1h", wid[47], 140);
      chk("latch_len", idle_c - done_t[1], 60000);
    end
    // reset in the middle of bit 10 while channel 0 is high
    @(posedge clk); #1 vld_b = 1'b1; data_b = {24'h000000, 24'hFFFFFF};
    @(posedge clk); #1 vld_b = 1'b0;
    repeat (2505) @(posedge clk);
    #1 chk("pre_rst_high", line_b[0], 1);
    rst_b = 1'b1;
    #1 chk("rst_line_low", line_b, 0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", rdy_b, 1);
    chk("post_rst_busy", busy_b, 0);
    repeat (20) @(negedge clk);
    chk("post_rst_no_done", done_t.size(), 2);
  endtask

  task automatic run_small();
    logic [23:0] s0, s1;
    int x, idle_c;
    bit ok;
    s0 = '0; s1 = '0; idle_c = 0;
    repeat (3) @(posedge clk);
    #1 rst_s = 1'b0;
    @(negedge clk);
    chk("s_rst_rdy", rdy_s, 1);
    chk("s_rst_busy", busy_s, 0);
    chk("s_rst_line", line_s, 0);
    @(posedge clk); #1 vld_s = 1'b1; data_s = {8'h01, 8'h80};
    @(posedge clk); #1 vld_s = 1'b0; data_s = 16'($urandom);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      s0 = {s0[22:0], line_s[0]};
      s1 = {s1[22:0], line_s[1]};
    end
    chk("s_ch0_wave", s0, 24'b110_100_100_100_100_100_100_100);
    chk("s_ch1_wave", s1, 24'b100_100_100_100_100_100_100_110);
    @(negedge clk);
    chk("s_done_time", done_s, 1);
    // valid and latch together: word then latch period
    @(posedge clk); #1 vld_s = 1'b1; latch_s = 1'b1; data_s = 16'($urandom);
    x = cyc;
    @(posedge clk); #1 vld_s = 1'b0; latch_s = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy_s) begin idle_c = cyc; ok = 1'b1; end
    end
    chk("s_word_then_latch", idle_c - x, 29);
    // latch alone from idle
    @(posedge clk); #1 latch_s = 1'b1;
    x = cyc;
    @(posedge clk); #1 latch_s = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy_s) begin idle_c = cyc; ok = 1'b1; end
    end
    chk("s_latch_alone", idle_c - x, 5);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      vld_s   = ($urandom_range(0, 3) != 0);
      data_s  = 16'($urandom);
      latch_s = ($urandom_range(0, 29) == 0);
      rst_s   = ($urandom_range(0, 799) == 0);
    end
    @(posedge clk); #1 vld_s = 1'b0; latch_s = 1'b0; rst_s = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  initial begin
    fork
      run_big();
      run_small();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no end of test expected end before time limit");
    $fatal(1);
  end

endmodule
